// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: computes the architectural next PC, detects
// mispredictions, drives a held redirect and flush to fetch, and trains the BHT.

package risc_v_32i;
    localparam int REG_SIZE = 32;
endpackage

module branch_resolver #(
    parameter int REG_SIZE    = risc_v_32i::REG_SIZE,
    parameter int BHT_ENTRIES = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_is_branch,
    input  logic                ex_is_jal,
    input  logic                ex_is_jalr,
    input  logic [REG_SIZE-1:0] ex_pc,
    input  logic [REG_SIZE-1:0] ex_imm,
    input  logic [REG_SIZE-1:0] ex_rs1,
    input  logic [REG_SIZE-1:0] cmp_result,
    input  logic                ex_pred_taken,
    input  logic [REG_SIZE-1:0] ex_pred_target,

    input  logic [REG_SIZE-1:0] fetch_pc,
    output logic                pred_taken,

    output logic                redirect_valid,
    output logic [REG_SIZE-1:0] redirect_pc,
    input  logic                redirect_ready,
    output logic                flush,
    output logic                misalign_err,

    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t state;

    logic                any_class;
    logic                is_cond;
    logic                accept;
    logic [REG_SIZE-1:0] pc_rel_target;
    logic [REG_SIZE-1:0] jalr_sum;
    logic [REG_SIZE-1:0] target;
    logic [REG_SIZE-1:0] fallthrough;
    logic [REG_SIZE-1:0] actual_pc;
    logic                actual_taken;
    logic                misaligned;
    logic                mispredict;
    logic                train;
    logic [IDX_W-1:0]    ex_idx;
    logic [IDX_W-1:0]    fetch_idx;
    logic [1:0]          bht [BHT_ENTRIES];
    logic                unused_bits;

    assign ex_ready  = (state == IDLE);
    assign any_class = ex_is_branch | ex_is_jal | ex_is_jalr;
    assign is_cond   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    assign accept    = ex_valid & ex_ready & any_class;

    // Target selection follows the class priority jalr > jal > branch.
    always_comb begin
        pc_rel_target = ex_pc + ex_imm;
        jalr_sum      = ex_rs1 + ex_imm;
        fallthrough   = ex_pc + REG_SIZE'(4);
        if (ex_is_jalr) begin
            target = jalr_sum & ~REG_SIZE'(1);
        end else begin
            target = pc_rel_target;
        end
        actual_taken = is_cond ? cmp_result[0] : 1'b1;
        actual_pc    = actual_taken ? target : fallthrough;
        misaligned   = actual_taken & target[1];
        mispredict   = (actual_taken != ex_pred_taken) |
                       (actual_taken & (ex_pred_target != target));
    end

    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign train     = accept & is_cond & ~misaligned;

    // No bypass: a lookup in the same cycle as an update sees the old counter.
    assign pred_taken = bht[fetch_idx][1];

    assign unused_bits = ^{fetch_pc[REG_SIZE-1:IDX_W+2], fetch_pc[1:0],
                           cmp_result[REG_SIZE-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (train) begin
            if (cmp_result[0]) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (accept) begin
            branch_count <= branch_count + 32'd1;
            if (mispredict & ~misaligned) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

    // Misaligned taken targets raise an error instead of redirecting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            misalign_err   <= 1'b0;
        end else begin
            flush        <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else if (mispredict) begin
                            state          <= REDIRECT;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= actual_pc;
                            flush          <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
